// File: rtl/gate_bank_sweep.sv
// gate_bank_sweep: registered 3-input gate bank with valid/ready output slot
// and a self-sweep mode that walks every {a,b,c} pattern into a signature.
`default_nettype none

module gate_bank_sweep #(
  parameter int WIDTH = 4,
  parameter int CW    = 3 * WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7*WIDTH-1:0]   y,
  output logic                 out_last,
  output logic                 sweep_done,
  output logic [7*WIDTH-1:0]   sig
);

  localparam int YW = 7 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  op_c;
  logic [WIDTH-1:0]  g_and;
  logic [WIDTH-1:0]  g_or;
  logic [WIDTH-1:0]  g_xor;
  logic [YW-1:0]     y_nx;
  logic              slot_free;
  logic              ext_load;
  logic              sweep_load;
  logic              load;
  logic              consume;
  logic              cnt_last;
  logic              sweep_start;
  logic              sig_active;

  always_comb begin
    slot_free   = !out_valid || out_ready;
    in_ready    = slot_free && (state == IDLE) && !mode;
    ext_load    = in_valid && in_ready;
    sweep_load  = (state == SWEEP) && slot_free;
    load        = ext_load || sweep_load;
    consume     = out_valid && out_ready;
    cnt_last    = &cnt;
    sweep_start = ((state == IDLE) || (state == DONE)) && start && mode;
    sig_active  = (state == SWEEP) || (state == DRAIN);
    sweep_done  = (state == DONE);
  end

  // Operand source: the sweep counter supplies {a,b,c} while sweeping.
  always_comb begin
    if (state == SWEEP) begin
      op_a = cnt[CW-1:2*WIDTH];
      op_b = cnt[2*WIDTH-1:WIDTH];
      op_c = cnt[WIDTH-1:0];
    end else begin
      op_a = a;
      op_b = b;
      op_c = c;
    end
    g_and = op_a & op_b & op_c;
    g_or  = op_a | op_b | op_c;
    g_xor = op_a ^ op_b ^ op_c;
    y_nx  = {~op_a, ~g_xor, g_xor, ~g_or, ~g_and, g_or, g_and};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sweep_start) state_nx = SWEEP;
      SWEEP:   if (sweep_load && cnt_last) state_nx = DRAIN;
      DRAIN:   if (consume) state_nx = DONE;
      DONE: begin
        if (sweep_start) state_nx = SWEEP;
        else if (!mode)  state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      y         <= '0;
      sig       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nx;

      if (sweep_start) begin
        cnt <= '0;
        sig <= '0;
      end else begin
        if (sweep_load) cnt <= cnt + CW'(1);
        if (consume && sig_active) sig <= {sig[YW-2:0], sig[YW-1]} ^ y;
      end

      // A load wins over a consume so the slot refills without a bubble.
      if (load) begin
        y         <= y_nx;
        out_valid <= 1'b1;
        out_last  <= sweep_load && cnt_last;
      end else if (consume) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
